// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: FSM state encoding and helpers.
package timer_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_LOAD = 2'd1;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd2;
    localparam logic [STATE_W-1:0] ST_HOLD = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_RUN  = ST_RUN,
        S_HOLD = ST_HOLD
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s != S_IDLE);
    endfunction

endpackage

// File: rtl/updn_counter_core.sv
// N-bit up/down counter datapath; priority syn_clr > load > en.
module updn_counter_core #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] q_reg;
    logic [N-1:0] q_next;

    always_comb begin
        q_next = q_reg;
        if (syn_clr) begin
            q_next = '0;
        end else if (load) begin
            q_next = d;
        end else if (en) begin
            q_next = up ? (q_reg + N'(1)) : (q_reg - N'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: FSM + prescaler sequencing an up/down counter core.
// Optional input capture register enabled by defining TIMER_CAPTURE_EN.
module interval_timer_ctrl
    import timer_pkg::*;
#(
    parameter int N    = 8,
    parameter int PS_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            hold,
    input  logic            periodic,
    input  logic            dir_up,
    input  logic [N-1:0]    load_val,
    input  logic [PS_W-1:0] prescale,
`ifdef TIMER_CAPTURE_EN
    input  logic            capture,
    output logic [N-1:0]    cap_q,
`endif
    output logic            busy,
    output logic            done_tick,
    output logic [N-1:0]    q
);

    state_t          state_reg, state_next;
    logic [PS_W-1:0] ps_reg, ps_next;

    logic            periodic_reg;
    logic            dir_up_reg;
    logic [N-1:0]    load_val_reg;
    logic [PS_W-1:0] prescale_reg;

    logic [N-1:0]    term;
    logic [N-1:0]    start_val;
    logic [N-1:0]    eq_bits;
    logic            at_term;
    logic            active;
    logic            step_due;
    logic            cnt_clr;
    logic            cnt_load;
    logic            cnt_en;

    assign term      = dir_up_reg ? load_val_reg : '0;
    assign start_val = dir_up_reg ? '0 : load_val_reg;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_term_cmp
            assign eq_bits[gi] = (q[gi] == term[gi]);
        end
    endgenerate

    assign at_term = &eq_bits;

    // HOLD with hold released counts immediately, so a hold of k cycles delays expiry by exactly k.
    assign active   = ((state_reg == S_RUN) || (state_reg == S_HOLD)) && !hold && !stop;
    assign step_due = active && (ps_reg == prescale_reg);

    assign done_tick = step_due && at_term && !reset;
    assign busy      = is_busy(state_reg);

    // Periodic reload happens on the expiry edge itself, avoiding a LOAD bubble.
    assign cnt_clr  = stop;
    assign cnt_load = (state_reg == S_LOAD) || (step_due && at_term && periodic_reg);
    assign cnt_en   = step_due && !at_term;

    always_comb begin
        state_next = state_reg;
        if (stop) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: if (start) state_next = S_LOAD;
                S_LOAD: state_next = S_RUN;
                S_RUN, S_HOLD: begin
                    if (hold) begin
                        state_next = S_HOLD;
                    end else if (step_due && at_term && !periodic_reg) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_RUN;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ps_next = ps_reg;
        if (stop || (state_reg == S_LOAD)) begin
            ps_next = '0;
        end else if (active) begin
            ps_next = step_due ? '0 : (ps_reg + PS_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            ps_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ps_reg    <= ps_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            periodic_reg <= 1'b0;
            dir_up_reg   <= 1'b0;
            load_val_reg <= '0;
            prescale_reg <= '0;
        end else if ((state_reg == S_IDLE) && start && !stop) begin
            periodic_reg <= periodic;
            dir_up_reg   <= dir_up;
            load_val_reg <= load_val;
            prescale_reg <= prescale;
        end
    end

    updn_counter_core #(
        .N(N)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .syn_clr (cnt_clr),
        .load    (cnt_load),
        .en      (cnt_en),
        .up      (dir_up_reg),
        .d       (start_val),
        .q       (q)
    );

`ifdef TIMER_CAPTURE_EN
    logic [N-1:0] cap_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_reg <= '0;
        end else if (capture) begin
            cap_reg <= q;
        end
    end

    assign cap_q = cap_reg;
`endif

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Randomized + directed bench for interval_timer_ctrl against an elapsed-time reference model.
module tb_interval_timer_ctrl;

    localparam int N    = 8;
    localparam int PS_W = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            hold = 1'b0;
    logic            periodic = 1'b0;
    logic            dir_up = 1'b0;
    logic [N-1:0]    load_val = '0;
    logic [PS_W-1:0] prescale = '0;
    logic            busy;
    logic            done_tick;
    logic [N-1:0]    q;
`ifdef TIMER_CAPTURE_EN
    logic            capture = 1'b0;
    logic [N-1:0]    cap_q;
`endif

    interval_timer_ctrl #(.N(N), .PS_W(PS_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .hold      (hold),
        .periodic  (periodic),
        .dir_up    (dir_up),
        .load_val  (load_val),
        .prescale  (prescale),
`ifdef TIMER_CAPTURE_EN
        .capture   (capture),
        .cap_q     (cap_q),
`endif
        .busy      (busy),
        .done_tick (done_tick),
        .q         (q)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Reference model: phase 0 idle, 1 loading, 2 counting; m_e = active cycles into the interval.
    int m_phase = 0;
    int m_e     = 0;
    int m_qh    = 0;
    int m_per   = 0;
    int m_up    = 0;
    int m_l     = 0;
    int m_s     = 0;
    int m_cap   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int period();
        return (m_l + 1) * (m_s + 1);
    endfunction

    function automatic int model_q();
        int steps;
        if (m_phase != 2) return m_qh;
        steps = m_e / (m_s + 1);
        return m_up ? steps : (m_l - steps);
    endfunction

    function automatic bit done_due();
        return (m_phase == 2) && (m_e == period() - 1);
    endfunction

    task automatic scramble();
        periodic = 1'($urandom_range(0, 1));
        dir_up   = 1'($urandom_range(0, 1));
        load_val = ($urandom_range(0, 15) == 0) ? N'($urandom_range(0, 255)) : N'($urandom_range(0, 10));
        prescale = PS_W'($urandom_range(0, 3));
    endtask

    task automatic step(input logic st, input logic sp, input logic hd, input logic rs, input logic cp);
        int exp_q;
        int exp_done;
        start = st;
        stop  = sp;
        hold  = hd;
        reset = rs;
`ifdef TIMER_CAPTURE_EN
        capture = cp;
`endif
        @(negedge clk);
        exp_q    = model_q();
        exp_done = (done_due() && !hd && !sp && !rs) ? 1 : 0;
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("done_tick", 32'(done_tick), 32'(exp_done));
        check("q", 32'(q), 32'(exp_q));
`ifdef TIMER_CAPTURE_EN
        check("cap_q", 32'(cap_q), 32'(m_cap));
        if (rs) m_cap = 0;
        else if (cp) m_cap = exp_q;
`else
        if (cp) m_cap = exp_q;
`endif
        if (rs) begin
            m_phase = 0; m_qh = 0; m_e = 0;
            m_per = 0; m_up = 0; m_l = 0; m_s = 0;
        end else if (sp) begin
            m_phase = 0; m_qh = 0; m_e = 0;
        end else begin
            case (m_phase)
                0: if (st) begin
                    m_per = int'(periodic); m_up = int'(dir_up);
                    m_l = int'(load_val); m_s = int'(prescale);
                    m_phase = 1;
                    $display("start cyc=%0d periodic=%0d up=%0d load=%0d prescale=%0d",
                             cyc, m_per, m_up, m_l, m_s);
                end
                1: begin m_phase = 2; m_e = 0; end
                default: if (!hd) begin
                    if (m_e == period() - 1) begin
                        if (m_per != 0) m_e = 0;
                        else begin m_phase = 0; m_qh = m_up ? m_l : 0; end
                    end else begin
                        m_e++;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_timer(input logic per, input logic up, input int lv, input int ps);
        periodic = per;
        dir_up   = up;
        load_val = N'(lv);
        prescale = PS_W'(ps);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        scramble();
    endtask

    initial begin
        int guard;
        repeat (2) @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_q", 32'(q), 32'd0);

        // 1: one-shot down count 3 -> 0
        start_timer(1'b0, 1'b0, 3, 0);
        idle_cycles(8);
        check("t1_idle_q", 32'(q), 32'd0);

        // 2: periodic up, period 15
        start_timer(1'b1, 1'b1, 4, 2);
        idle_cycles(50);

        // 3: stop at q == 2
        guard = 0;
        while (!(m_phase == 2 && model_q() == 2) && guard < 60) begin
            idle_cycles(1);
            guard++;
        end
        check("t3_reach_q2", 32'(guard < 60), 32'd1);
`ifdef TIMER_CAPTURE_EN
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_cap", 32'(cap_q), 32'd2);
`endif
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(20);

        // 4: hold for 7 cycles mid-run
        start_timer(1'b0, 1'b1, 5, 1);
        idle_cycles(4);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(15);

        // 5: tick every cycle, start while busy, start+stop in idle
        start_timer(1'b1, 1'b0, 0, 0);
        idle_cycles(4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(2);

        // full-range up count: no overflow at 255
        start_timer(1'b0, 1'b1, 255, 0);
        idle_cycles(260);

        // 6: reset on the cycle a done is due
        start_timer(1'b1, 1'b1, 2, 1);
        guard = 0;
        while (!done_due() && guard < 40) begin
            idle_cycles(1);
            guard++;
        end
        check("t6_reach_done", 32'(guard < 40), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_cycles(3);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            logic st, sp, hd, rs, cp;
            scramble();
            st = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 80) == 0);
            hd = ($urandom_range(0, 6) == 0);
            rs = ($urandom_range(0, 600) == 0);
            cp = ($urandom_range(0, 4) == 0);
            step(st, sp, hd, rs, cp);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
